genie_mem_responder: RTL and testbench
======================================

# genie_mem_responder

Memory-side responder for the accelerator's external data-memory request interface (`wvalid`/`wready`/`waddr`/`wdata`, `rvalid`/`rready`/`raddr`/`rdata`). It serves word reads and writes from an internal single-port array with fixed, parameterised latency. It is used as the behavioural memory for the accelerator top in system simulation and as an on-chip scratch memory in FPGA builds. A backdoor port preloads weights and inputs and inspects results.

## Interface
- `ADDR_W`, 16: index width; the array holds 2^ADDR_W 32-bit words.
- `RD_LAT`, 2: cycles from read-request sample to the `rready` pulse; must be ≥1.
- `WR_LAT`, 1: cycles from write-request sample to the `wready` pulse; must be ≥1.

- `clk`  in  1  sole clock; everything is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `wvalid`  in  1  write request; the initiator holds it until `wready`.
- `wready`  out  1  one-cycle write-commit pulse.
- `waddr`  in  26  word address; held with `wvalid`.
- `wdata`  in  32  write data; held with `wvalid`.
- `rvalid`  in  1  read request; the initiator holds it until `rready`.
- `rready`  out  1  one-cycle pulse; `rdata` is valid in this cycle only.
- `raddr`  in  26  word address; held with `rvalid`.
- `rdata`  out  32  read data; 0 when `rready` is low.
- `bd_we`  in  1  backdoor write enable.
- `bd_addr`  in  ADDR_W  backdoor index.
- `bd_wdata`  in  32  backdoor write data.
- `bd_rdata`  out  32  combinational `mem[bd_addr]`.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `err`  out  1  sticky error flag: out-of-range access or protocol violation.

## Operation
- FSM states: IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP.
- Requests are serviced one at a time. There is no pipelining and no outstanding-request queue.
- In IDLE, the FSM samples `rvalid` and `wvalid`.
  - If exactly one is high, that request is accepted.
  - If both are high, round-robin priority decides. The priority bit resets to "write first" and toggles after each accepted request that had contention.
- On accept, the FSM latches the address and data and loads a counter with LAT-1.
  - If LAT-1 is 0, it goes directly to the RESP state; otherwise it goes to the WAIT state.
  - In WAIT, the counter decrements once per cycle. When it reaches 0, the FSM moves to RESP.
- RD_RESP: `rready`=1 and `rdata` = the registered value of `mem[idx]`. That register is loaded on the edge that enters RD_RESP. Next state is IDLE.
- WR_RESP: `wready`=1, and `mem[idx]` ← latched `wdata` at the end of the cycle. Next state is IDLE.
- `idx` = addr[ADDR_W-1:0]. An address is out of range when addr[25:ADDR_W] ≠ 0.
  - Out-of-range read: responds normally with `rdata`=0 and sets `err`.
  - Out-of-range write: pulses `wready`, drops the write, and sets `err`.
- Protocol violation: the active request's valid drops before its pulse.
  - The responder still completes the transaction and pulses.
  - A read returns data for the latched address; a write commits the latched data.
  - `err` is set.
- Backdoor:
  - `bd_we` writes `mem[bd_addr]` at the clock edge, in any state.
  - If it collides with a front-door write commit to the same index on the same edge, the front-door write wins.
  - `bd_rdata` is combinational.
- Reset:
  - FSM → IDLE; counter, priority bit, latched address/data, `rdata` register and `err` are cleared.
  - Memory contents are retained.
  - A transaction in flight when reset asserts is aborted; no pulse is issued for it.

## Timing
- Reset values: `wready`=0, `rready`=0, `rdata`=0, `busy`=0, `err`=0.
- A request sampled in IDLE at cycle t produces its pulse at cycle t+LAT.
- The FSM is back in IDLE at t+LAT+1, where a new request can be sampled. Peak throughput is one access per LAT+1 cycles.
- The initiator may change its address or data in the cycle after the pulse. The responder does not re-sample the old request, because it is in RESP during the pulse and samples only in IDLE.
- Read-after-write to the same index returns the new data. The write commits at the WR_RESP edge, which precedes any later read's RESP load.
- `busy` goes high in the cycle after accept and stays high through the RESP cycle.
- `bd_rdata` reflects a backdoor or front-door write from the following cycle onward.

## Test plan
- **Reset values:** assert `rst` for 2 cycles with random inputs → all outputs 0; memory preloaded via backdoor is still intact.
- **Read latency, RD_LAT=2:** backdoor `mem[5]`=0xDEADBEEF; `rvalid`=1, `raddr`=5 at cycle 10 → `rready`=1 and `rdata`=0xDEADBEEF at cycle 12 only; `rdata`=0 at cycles 11 and 13.
- **Write then read:** write `waddr`=7, `wdata`=0x1234 → `wready` at t+1; read of 7 is sampled at t+2 → returns 0x1234 at t+4; `bd_rdata`@7 = 0x1234.
- **Contention:** `rvalid` and `wvalid` both held continuously from reset → grants alternate W, R, W, R; neither request starves.
- **Out of range, ADDR_W=16:** read `raddr`=0x10000 → `rdata`=0 and `err`=1; write 0x10003 → `wready` pulses, `mem[3]` is unchanged, `err` stays 1 until `rst`.
- **Abort and violation:**
  - `rst` asserted in RD_WAIT → no `rready` pulse; FSM in IDLE after reset.
  - `rvalid` dropped mid-wait → `rready` still pulses with the latched address's data, and `err`=1.

Source files
------------

// File: rtl/genie_mem_if.sv
// Request/response bus between an initiator and the memory responder.
// The initiator holds valid, address and data until the matching one-cycle ready pulse.
interface genie_mem_if;
  logic        wvalid;
  logic        wready;
  logic [25:0] waddr;
  logic [31:0] wdata;
  logic        rvalid;
  logic        rready;
  logic [25:0] raddr;
  logic [31:0] rdata;

  modport master (
    output wvalid, waddr, wdata, rvalid, raddr,
    input  wready, rready, rdata
  );

  modport slave (
    input  wvalid, waddr, wdata, rvalid, raddr,
    output wready, rready, rdata
  );
endinterface

// File: rtl/genie_mem_responder.sv
// Fixed-latency word memory responder with a backdoor port for preload and inspection.
// Serves one request at a time; contention is resolved round-robin, starting with writes.
module genie_mem_responder #(
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  genie_mem_if.slave        bus,
  input  logic              bd_we,
  input  logic [ADDR_W-1:0] bd_addr,
  input  logic [31:0]       bd_wdata,
  output logic [31:0]       bd_rdata,
  output logic              busy,
  output logic              err
);

  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(WR_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_RESP,
    WR_WAIT,
    WR_RESP
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [25:0]       addr_reg, addr_next;
  logic [31:0]       data_reg, data_next;
  logic              prio_reg, prio_next;   // 0: write wins contention, 1: read wins
  logic              err_reg, err_next;
  logic [31:0]       rdata_reg;

  logic [31:0]       mem [2**ADDR_W];

  function automatic logic is_oor(input logic [25:0] a);
    return (a >> ADDR_W) != 26'd0;
  endfunction

  always_comb begin
    logic grant_rd;
    logic grant_wr;
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    prio_next  = prio_reg;
    err_next   = err_reg;
    grant_rd   = 1'b0;
    grant_wr   = 1'b0;

    case (state_reg)
      IDLE: begin
        grant_rd = bus.rvalid && (!bus.wvalid || prio_reg);
        grant_wr = bus.wvalid && (!bus.rvalid || !prio_reg);
        if (bus.rvalid && bus.wvalid) begin
          prio_next = ~prio_reg;
        end
        if (grant_rd) begin
          addr_next  = bus.raddr;
          cnt_next   = RD_CNT;
          state_next = (RD_LAT == 1) ? RD_RESP : RD_WAIT;
          if (is_oor(bus.raddr)) err_next = 1'b1;
        end else if (grant_wr) begin
          addr_next  = bus.waddr;
          data_next  = bus.wdata;
          cnt_next   = WR_CNT;
          state_next = (WR_LAT == 1) ? WR_RESP : WR_WAIT;
          if (is_oor(bus.waddr)) err_next = 1'b1;
        end
      end
      RD_WAIT: begin
        if (!bus.rvalid) err_next = 1'b1;
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CNT_W'(1)) state_next = RD_RESP;
      end
      RD_RESP: begin
        if (!bus.rvalid) err_next = 1'b1;
        state_next = IDLE;
      end
      WR_WAIT: begin
        if (!bus.wvalid) err_next = 1'b1;
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CNT_W'(1)) state_next = WR_RESP;
      end
      WR_RESP: begin
        if (!bus.wvalid) err_next = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
      prio_reg  <= 1'b0;
      err_reg   <= 1'b0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      prio_reg  <= prio_next;
      err_reg   <= err_next;
      // Read data is captured on the edge that enters RD_RESP.
      if (state_next == RD_RESP && state_reg != RD_RESP) begin
        rdata_reg <= is_oor(addr_next) ? 32'd0 : mem[addr_next[ADDR_W-1:0]];
      end
    end
  end

  // Front-door commit is written last so it wins a same-index collision with the backdoor.
  always_ff @(posedge clk) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_wdata;
    end
    if (!rst && state_reg == WR_RESP && !is_oor(addr_reg)) begin
      mem[addr_reg[ADDR_W-1:0]] <= data_reg;
    end
  end

  assign bus.rready = (state_reg == RD_RESP);
  assign bus.wready = (state_reg == WR_RESP);
  assign bus.rdata  = (state_reg == RD_RESP) ? rdata_reg : 32'd0;
  assign bd_rdata   = mem[bd_addr];
  assign busy       = (state_reg != IDLE);
  assign err        = err_reg;

endmodule

// File: tb/tb_genie_mem_responder.sv
// Directed bench for genie_mem_responder: vector table for single accesses plus
// hand-written sequences for reset, contention, collision, abort and protocol errors.
module tb_genie_mem_responder;
  localparam int ADDR_W = 16;
  localparam int RD_LAT = 2;
  localparam int WR_LAT = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              bd_we;
  logic [ADDR_W-1:0] bd_addr;
  logic [31:0]       bd_wdata;
  logic [31:0]       bd_rdata;
  logic              busy;
  logic              err;

  int n_checks = 0;
  int n_errors = 0;

  genie_mem_if bus ();

  genie_mem_responder #(
    .ADDR_W(ADDR_W),
    .RD_LAT(RD_LAT),
    .WR_LAT(WR_LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .bd_we    (bd_we),
    .bd_addr  (bd_addr),
    .bd_wdata (bd_wdata),
    .bd_rdata (bd_rdata),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic [25:0] addr;
    logic [31:0] data;    // write data, or expected read data
    logic [31:0] exp_bd;  // expected backdoor view of addr[ADDR_W-1:0] afterwards
    logic        exp_err;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bd_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bd_we = 1'b1; bd_addr = a; bd_wdata = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  // Issue one request at the next cycle and check the pulse lands exactly LAT cycles later.
  task automatic req(input logic is_wr, input logic [25:0] addr, input logic [31:0] data,
                     input string name);
    int lat;
    lat = is_wr ? WR_LAT : RD_LAT;
    @(posedge clk); #1;
    if (is_wr) begin
      bus.wvalid = 1'b1; bus.waddr = addr; bus.wdata = data;
    end else begin
      bus.rvalid = 1'b1; bus.raddr = addr;
    end
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      check({name, "_pulse"}, {31'd0, is_wr ? bus.wready : bus.rready}, {31'd0, k == lat});
      check({name, "_rdata"}, bus.rdata, (!is_wr && k == lat) ? data : 32'd0);
      if (k == lat) check({name, "_busy"}, {31'd0, busy}, 32'd1);
    end
    @(posedge clk); #1;
    bus.wvalid = 1'b0; bus.rvalid = 1'b0;
    @(negedge clk);
    check({name, "_after_pulse"}, {31'd0, bus.wready | bus.rready}, 32'd0);
    check({name, "_after_rdata"}, bus.rdata, 32'd0);
    $display("txn %s %s addr=0x%07h data=0x%08h", name, is_wr ? "WR" : "RD", addr, data);
  endtask

  initial begin
    int grants;
    rst = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
    bus.wvalid = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.rvalid = 1'b0; bus.raddr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    bd_write(16'd0, 32'h0000_0000);
    bd_write(16'd3, 32'h0000_0333);
    bd_write(16'd5, 32'hDEAD_BEEF);

    // Reset with random front-door activity: all outputs stay low, memory survives.
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      bus.rvalid = 1'($urandom); bus.wvalid = 1'($urandom);
      bus.raddr = 26'($urandom); bus.waddr = 26'($urandom); bus.wdata = $urandom;
      @(negedge clk);
      check("rst_wready", {31'd0, bus.wready}, 32'd0);
      check("rst_rready", {31'd0, bus.rready}, 32'd0);
      check("rst_rdata", bus.rdata, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0; bus.rvalid = 1'b0; bus.wvalid = 1'b0;
    bd_addr = 16'd5;
    @(negedge clk);
    check("rst_mem_kept", bd_rdata, 32'hDEAD_BEEF);
    check("rst_busy_idle", {31'd0, busy}, 32'd0);
    $display("txn reset with random inputs");

    // Write 7 then read it back as soon as the FSM returns to IDLE.
    @(posedge clk); #1;
    bus.wvalid = 1'b1; bus.waddr = 26'd7; bus.wdata = 32'h1234;
    @(negedge clk);
    check("raw_wready_t0", {31'd0, bus.wready}, 32'd0);
    @(negedge clk);
    check("raw_wready_t1", {31'd0, bus.wready}, 32'd1);
    @(posedge clk); #1;
    bus.wvalid = 1'b0; bus.rvalid = 1'b1; bus.raddr = 26'd7;
    for (int k = 0; k <= RD_LAT; k++) begin
      @(negedge clk);
      check("raw_rready", {31'd0, bus.rready}, {31'd0, k == RD_LAT});
      check("raw_rdata", bus.rdata, (k == RD_LAT) ? 32'h1234 : 32'd0);
    end
    @(posedge clk); #1;
    bus.rvalid = 1'b0; bd_addr = 16'd7;
    @(negedge clk);
    check("raw_bd_rdata", bd_rdata, 32'h1234);
    $display("txn write-then-read addr=7 data=0x00001234");

    // Backdoor and front-door write to the same index on the same edge.
    @(posedge clk); #1;
    bus.wvalid = 1'b1; bus.waddr = 26'h40; bus.wdata = 32'hF00D;
    @(posedge clk); #1;
    bd_we = 1'b1; bd_addr = 16'h40; bd_wdata = 32'hBEEF;
    @(negedge clk);
    check("coll_wready", {31'd0, bus.wready}, 32'd1);
    @(posedge clk); #1;
    bd_we = 1'b0; bus.wvalid = 1'b0;
    @(negedge clk);
    check("coll_front_wins", bd_rdata, 32'hF00D);
    $display("txn collision addr=0x40 front=0x0000f00d back=0x0000beef");

    // Contention from reset: grants must alternate W, R, W, R.
    @(posedge clk); #1;
    rst = 1'b1;
    bus.wvalid = 1'b1; bus.waddr = 26'h30; bus.wdata = 32'h5555;
    bus.rvalid = 1'b1; bus.raddr = 26'd5;
    @(posedge clk); #1;
    rst = 1'b0;
    grants = 0;
    for (int c = 0; c < 40 && grants < 4; c++) begin
      @(negedge clk);
      if (bus.wready || bus.rready) begin
        check("cont_grant_is_wr", {31'd0, bus.wready}, {31'd0, (grants % 2) == 0});
        if (bus.rready) check("cont_rdata", bus.rdata, 32'hDEAD_BEEF);
        $display("txn contention grant %0d %s", grants, bus.wready ? "WR" : "RD");
        grants++;
      end
    end
    if (grants < 4) begin
      n_checks++;
      n_errors++;
      $display("FAIL cont_timeout: got %0d grants required 4", grants);
    end
    @(posedge clk); #1;
    bus.wvalid = 1'b0; bus.rvalid = 1'b0;
    @(negedge clk);
    check("cont_err", {31'd0, err}, 32'd0);

    // Single accesses, including out-of-range ones at the end.
    vecs = '{
      '{1'b0, 26'd5,       32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0},
      '{1'b1, 26'h20,      32'h1111_2222, 32'h1111_2222, 1'b0},
      '{1'b0, 26'h20,      32'h1111_2222, 32'h1111_2222, 1'b0},
      '{1'b1, 26'hFFFF,    32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0},
      '{1'b0, 26'hFFFF,    32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0},
      '{1'b1, 26'h21,      32'h5A5A_5A5A, 32'h5A5A_5A5A, 1'b0},
      '{1'b0, 26'h10000,   32'h0000_0000, 32'h0000_0000, 1'b1},
      '{1'b1, 26'h10003,   32'hBADB_AD00, 32'h0000_0333, 1'b1},
      '{1'b0, 26'd3,       32'h0000_0333, 32'h0000_0333, 1'b1}
    };
    for (int i = 0; i < 9; i++) begin
      req(vecs[i].is_wr, vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
      bd_addr = vecs[i].addr[ADDR_W-1:0];
      #1;
      check($sformatf("vec%0d_bd", i), bd_rdata, vecs[i].exp_bd);
      check($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
    end

    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("err_cleared", {31'd0, err}, 32'd0);

    // Reset during RD_WAIT aborts the read with no pulse.
    @(posedge clk); #1;
    bus.rvalid = 1'b1; bus.raddr = 26'd5;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_busy_wait", {31'd0, busy}, 32'd1);
    rst = 1'b1; bus.rvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("abort_no_rready", {31'd0, bus.rready}, 32'd0);
      check("abort_idle", {31'd0, busy}, 32'd0);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_no_rready_post", {31'd0, bus.rready}, 32'd0);
    check("abort_err", {31'd0, err}, 32'd0);
    $display("txn abort read addr=5");

    // rvalid dropped while waiting: read still completes from the latched address.
    @(posedge clk); #1;
    bus.rvalid = 1'b1; bus.raddr = 26'h20;
    @(posedge clk); #1;
    bus.rvalid = 1'b0; bus.raddr = 26'd5;
    @(negedge clk);
    check("viol_wait_rready", {31'd0, bus.rready}, 32'd0);
    @(negedge clk);
    check("viol_rready", {31'd0, bus.rready}, 32'd1);
    check("viol_rdata", bus.rdata, 32'h1111_2222);
    check("viol_err", {31'd0, err}, 32'd1);
    @(negedge clk);
    check("viol_done", {31'd0, bus.rready}, 32'd0);
    $display("txn violation read addr=0x20");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
